// File: rtl/unstriping_2lane_pkg.sv
// Shared constants for the two-lane un-striper: default word width and
// per-lane FIFO depth, plus the lane index encoding used by the merge pointer.
package unstriping_2lane_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF = 4;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/unstriping_2lane_lane_fifo.sv
// lane_fifo: per-lane word buffer absorbing lane skew and downstream stall.
// Ports:
//   clk_2f, reset   clock and synchronous active-high reset
//   push, wdata     write request and word; ignored when full unless popped
//   pop             read request; ignored when empty
//   rdata           head word (combinational from storage)
//   empty, full     occupancy flags derived from the count register
module lane_fifo
    import unstriping_2lane_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign rdata   = mem_q[rd_ptr_q];

    // A same-edge pop frees a slot, so a full FIFO still takes the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the count.
    always_ff @(posedge clk_2f) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/unstriping_2lane.sv
// unstriping_2lane: merges two independently arriving lanes back into one
// ordered stream, strictly alternating lane 0, lane 1, lane 0, ...
// Ports:
//   clk_2f, reset        clock and synchronous active-high reset
//   lane_0/valid_0       lane 0 word and strobe
//   lane_1/valid_1       lane 1 word and strobe
//   ready_in             downstream accepts data_out this cycle
//   data_out/valid_out   registered merged word and its valid
//   next_lane            lane the merger pops next
//   err_overflow         sticky: a word was dropped on a full lane FIFO
module unstriping_2lane
    import unstriping_2lane_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_1,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             next_lane,
    output logic             err_overflow
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             next_lane_q, next_lane_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] rdata_0, rdata_1;
    logic             empty_0, empty_1, full_0, full_1;
    logic             pop_0, pop_1;
    logic             out_free_c, head_empty_c, drop_c;
    logic [WIDTH-1:0] head_data_c;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid_0),
        .pop    (pop_0),
        .wdata  (lane_0),
        .rdata  (rdata_0),
        .empty  (empty_0),
        .full   (full_0)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid_1),
        .pop    (pop_1),
        .wdata  (lane_1),
        .rdata  (rdata_1),
        .empty  (empty_1),
        .full   (full_1)
    );

    // Output register may load when empty or being drained this edge.
    assign out_free_c   = !valid_q || ready_in;
    assign head_empty_c = (next_lane_q == LANE0) ? empty_0 : empty_1;
    assign head_data_c  = (next_lane_q == LANE0) ? rdata_0 : rdata_1;

    // Only the lane named by the merge pointer is ever popped.
    assign pop_0 = out_free_c && (next_lane_q == LANE0) && !empty_0;
    assign pop_1 = out_free_c && (next_lane_q == LANE1) && !empty_1;

    assign drop_c = (valid_0 && full_0 && !pop_0) || (valid_1 && full_1 && !pop_1);

    // Output register, merge pointer and sticky error next-state.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        next_lane_d = next_lane_q;
        err_d       = err_q || drop_c;
        if (out_free_c) begin
            if (!head_empty_c) begin
                data_d      = head_data_c;
                valid_d     = 1'b1;
                next_lane_d = ~next_lane_q;
            end else begin
                valid_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            next_lane_q <= LANE0;
            err_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            next_lane_q <= next_lane_d;
            err_q       <= err_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign next_lane    = next_lane_q;
    assign err_overflow = err_q;

endmodule
